// File: rtl/scan_digit_decoder.sv
// scan_digit_decoder: active-low digit-select driver for a multiplexed
// common-anode 7-segment bank. In scan mode it steps through the enabled
// digits on its own, blanking the first DEAD cycles of every slot so the
// previous digit's segment data cannot ghost onto the next one. In static
// mode it decodes sel_in with one cycle of registered latency.
module scan_digit_decoder #(
    parameter int DIGITS = 8,
    parameter int DIV    = 50000,
    parameter int DEAD   = 4,
    parameter int IDX_W  = (DIGITS > 2) ? $clog2(DIGITS) : 1,
    parameter int CNT_W  = $clog2(DIV)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_en,
    input  logic [IDX_W-1:0]  sel_in,
    input  logic [DIGITS-1:0] digit_mask,
    output logic [DIGITS-1:0] out,
    output logic [IDX_W-1:0]  idx,
    output logic              slot_tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W:0]   DIGITS_L = (IDX_W + 1)'(DIGITS);

    logic [CNT_W-1:0] cnt;
    logic             mode_r;
    logic             valid;
    logic             in_range;
    logic             in_dead;
    logic [IDX_W-1:0] nxt_idx;

    // Next enabled digit after cur, wrapping; an out-of-range cur restarts
    // the search at digit 0. With no digit enabled the search start itself
    // is returned, so the index keeps rotating while the bank stays dark.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur,
                                                   input logic [DIGITS-1:0] m);
        int               s;
        int               j;
        logic [IDX_W-1:0] jj;
        logic [IDX_W-1:0] r;
        if (int'(cur) >= DIGITS - 1) begin
            s = 0;
        end else begin
            s = int'(cur) + 1;
        end
        r = IDX_W'(s);
        // Walk from the far end back to s so the closest enabled digit wins.
        for (int k = DIGITS - 1; k >= 0; k--) begin
            j = s + k;
            if (j >= DIGITS) begin
                j = j - DIGITS;
            end
            jj = IDX_W'(j);
            if (m[jj]) begin
                r = jj;
            end
        end
        return r;
    endfunction

    assign in_range = ({1'b0, idx} < DIGITS_L);
    assign nxt_idx  = next_idx(idx, digit_mask);

    // Dead-time window covers slot cycles 0..DEAD-1; none at all when DEAD=0.
    generate
        if (DEAD == 0) begin : g_no_dead
            assign in_dead = 1'b0;
        end else begin : g_dead
            assign in_dead = (cnt < CNT_W'(DEAD));
        end
    endgenerate

    // Slot counter, selected index, mode pipeline and slot pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= '0;
            mode_r    <= 1'b0;
            valid     <= 1'b0;
            slot_tick <= 1'b0;
        end else begin
            valid  <= 1'b1;
            mode_r <= scan_en;
            if (!scan_en) begin
                idx       <= sel_in;
                cnt       <= '0;
                slot_tick <= 1'b0;
            end else if (cnt == CNT_LAST) begin
                cnt       <= '0;
                slot_tick <= 1'b1;
                idx       <= nxt_idx;
            end else begin
                cnt       <= cnt + CNT_W'(1);
                slot_tick <= 1'b0;
            end
        end
    end

    // Active-low one-hot decode; the mask acts immediately, not at the slot edge.
    always_comb begin
        out = '1;
        if (valid && in_range && digit_mask[idx] && !(mode_r && in_dead)) begin
            out = ~(DIGITS'(1) << idx);
        end
    end

endmodule
